regfile_write_arbiter: RTL and testbench

//   Owns the single write port of the 32x32 register file. After reset it sequences
//   a clear sweep that zeroes every register, then shares the write port between two

---
 rtl/regfile_write_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: clear sweep after reset,
// then round-robin sharing of the write port between the ALU (A) and load (B)
// writeback paths. Every output is registered so it is stable across the
// register file's negedge write.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_a,
  input  logic [ADDR_W-1:0] i_reg_a,
  input  logic [DATA_W-1:0] i_data_a,
  output logic              o_gnt_a,
  input  logic              i_req_b,
  input  logic [ADDR_W-1:0] i_reg_b,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_gnt_b,
  output logic              o_reg_write,
  output logic [ADDR_W-1:0] o_write_reg,
  output logic [DATA_W-1:0] o_data_write,
  output logic              o_init_done,
  output logic [7:0]        o_drop_cnt
);

  // state  | meaning
  // S_INIT | clear sweep, one register zeroed per cycle, requests ignored
  // S_RUN  | round-robin arbitration between A and B
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_rr_b;      // 1: B preferred on the next contention
  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_wreg_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                w_drop_inc;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= INIT_CLEAR ? S_INIT : S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave the sweep once the last index has been presented
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_idx == LAST_IDX) w_state_nxt = S_RUN;
  end

  // Output decode: next values for the registered write port and grants
  always_comb begin
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_we_nxt    = 1'b0;
    w_wreg_nxt  = o_write_reg;
    w_wdata_nxt = o_data_write;
    w_drop_inc  = 1'b0;
    if (r_state == S_INIT) begin
      w_we_nxt    = 1'b1;
      w_wreg_nxt  = r_idx;
      w_wdata_nxt = '0;
    end else begin
      w_gnt_a = i_req_a & (~i_req_b | ~r_rr_b);
      w_gnt_b = i_req_b & (~i_req_a |  r_rr_b);
      if (w_gnt_a) begin
        w_wreg_nxt  = i_reg_a;
        w_wdata_nxt = i_data_a;
        w_we_nxt    = |i_reg_a;
        w_drop_inc  = ~|i_reg_a;
      end else if (w_gnt_b) begin
        w_wreg_nxt  = i_reg_b;
        w_wdata_nxt = i_data_b;
        w_we_nxt    = |i_reg_b;
        w_drop_inc  = ~|i_reg_b;
      end
    end
  end

  // Sweep index and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_rr_b <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + ADDR_W'(1);
      if (w_gnt_a)      r_rr_b <= 1'b1;
      else if (w_gnt_b) r_rr_b <= 1'b0;
    end
  end

  // Registered outputs; writes to $0 are granted but suppressed and counted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt_a      <= 1'b0;
      o_gnt_b      <= 1'b0;
      o_reg_write  <= 1'b0;
      o_write_reg  <= '0;
      o_data_write <= '0;
      o_init_done  <= ~INIT_CLEAR;
      o_drop_cnt   <= 8'd0;
    end else begin
      o_gnt_a      <= w_gnt_a;
      o_gnt_b      <= w_gnt_b;
      o_reg_write  <= w_we_nxt;
      o_write_reg  <= w_wreg_nxt;
      o_data_write <= w_wdata_nxt;
      o_init_done  <= (r_state == S_RUN);
      if (w_drop_inc && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: inputs are driven on the
// negedge, the expected registered outputs for the following posedge are
// queued at the same time and compared on the next negedge.
module tb_regfile_write_arbiter;

  typedef logic [48:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [4:0]  reg_a = '0, reg_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, reg_write, init_done;
  logic [4:0]  write_reg;
  logic [31:0] data_write;
  logic [7:0]  drop_cnt;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t exp_v;
  vec_t dut_v;
  logic [7:0] e_drop = 8'd0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_a(req_a), .i_reg_a(reg_a), .i_data_a(data_a), .o_gnt_a(gnt_a),
    .i_req_b(req_b), .i_reg_b(reg_b), .i_data_b(data_b), .o_gnt_b(gnt_b),
    .o_reg_write(reg_write), .o_write_reg(write_reg), .o_data_write(data_write),
    .o_init_done(init_done), .o_drop_cnt(drop_cnt)
  );

  assign dut_v = {gnt_a, gnt_b, reg_write, init_done, drop_cnt, write_reg, data_write};

  function automatic vec_t pk(input logic ga, input logic gb, input logic we,
                              input logic id, input logic [7:0] dc,
                              input logic [4:0] wr, input logic [31:0] wd);
    return {ga, gb, we, id, dc, wr, wd};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    sb.push_back(pk(0, 0, 0, 0, 8'd0, 5'd0, 32'd0));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL reset got=%h exp=%h", dut_v, exp_v); end
  endtask

  // Sweep with a request pending that must be ignored
  task automatic test_init_sweep();
    rst = 1'b0;
    req_a = 1'b1; reg_a = 5'd9; data_a = 32'h55;
    for (int k = 0; k < 32; k++) sb.push_back(pk(0, 0, 1, 0, 8'd0, 5'(k), 32'd0));
    sb.push_back(pk(0, 0, 0, 1, 8'd0, 5'd31, 32'd0));
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (dut_v !== exp_v) begin bad++; $display("FAIL sweep k=%0d got=%h exp=%h", k, dut_v, exp_v); end
      if (k == 19) req_a = 1'b0;
    end
  endtask

  task automatic test_single_a();
    req_a = 1'b1; reg_a = 5'd5; data_a = 32'hDEADBEEF;
    sb.push_back(pk(1, 0, 1, 1, e_drop, 5'd5, 32'hDEADBEEF));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL single_a got=%h exp=%h", dut_v, exp_v); end
    req_a = 1'b0;
    sb.push_back(pk(0, 0, 0, 1, e_drop, 5'd5, 32'hDEADBEEF));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL single_a_idle got=%h exp=%h", dut_v, exp_v); end
  endtask

  task automatic test_drop_b();
    req_b = 1'b1; reg_b = 5'd0; data_b = 32'hFFFF;
    e_drop = 8'd1;
    sb.push_back(pk(0, 1, 0, 1, e_drop, 5'd0, 32'hFFFF));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL drop_b got=%h exp=%h", dut_v, exp_v); end
    req_b = 1'b0;
    sb.push_back(pk(0, 0, 0, 1, e_drop, 5'd0, 32'hFFFF));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL drop_b_idle got=%h exp=%h", dut_v, exp_v); end
  endtask

  // Pointer is at A here (last grant went to B)
  task automatic test_back_to_back();
    req_a = 1'b1; reg_a = 5'd3; data_a = 32'hAAAA;
    req_b = 1'b1; reg_b = 5'd4; data_b = 32'hBBBB;
    sb.push_back(pk(1, 0, 1, 1, e_drop, 5'd3, 32'hAAAA));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (dut_v !== exp_v) begin bad++; $display("FAIL b2b i=%0d got=%h exp=%h", i, dut_v, exp_v); end
      if (i < 3) begin
        if ((i + 1) % 2 == 0) sb.push_back(pk(1, 0, 1, 1, e_drop, 5'd3, 32'hAAAA));
        else                  sb.push_back(pk(0, 1, 1, 1, e_drop, 5'd4, 32'hBBBB));
      end else begin
        req_a = 1'b0; req_b = 1'b0;
        sb.push_back(pk(0, 0, 0, 1, e_drop, 5'd4, 32'hBBBB));
      end
    end
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL b2b_idle got=%h exp=%h", dut_v, exp_v); end
  endtask

  // Pointer is at A again after an even number of alternating grants
  task automatic test_same_reg();
    req_a = 1'b1; reg_a = 5'd7; data_a = 32'd1;
    req_b = 1'b1; reg_b = 5'd7; data_b = 32'd2;
    sb.push_back(pk(1, 0, 1, 1, e_drop, 5'd7, 32'd1));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL same_reg_a got=%h exp=%h", dut_v, exp_v); end
    req_a = 1'b0;
    sb.push_back(pk(0, 1, 1, 1, e_drop, 5'd7, 32'd2));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL same_reg_b got=%h exp=%h", dut_v, exp_v); end
    req_b = 1'b0;
    sb.push_back(pk(0, 0, 0, 1, e_drop, 5'd7, 32'd2));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL same_reg_idle got=%h exp=%h", dut_v, exp_v); end
  endtask

  // Lone requester to $0 is granted every cycle; counter must stop at 255
  task automatic test_drop_saturate();
    req_a = 1'b1; reg_a = 5'd0; data_a = 32'h77;
    e_drop = (e_drop == 8'hFF) ? 8'hFF : e_drop + 8'd1;
    sb.push_back(pk(1, 0, 0, 1, e_drop, 5'd0, 32'h77));
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (dut_v !== exp_v) begin bad++; $display("FAIL drop_sat i=%0d got=%h exp=%h", i, dut_v, exp_v); end
      if (i < 259) begin
        e_drop = (e_drop == 8'hFF) ? 8'hFF : e_drop + 8'd1;
        sb.push_back(pk(1, 0, 0, 1, e_drop, 5'd0, 32'h77));
      end else begin
        req_a = 1'b0;
        sb.push_back(pk(0, 0, 0, 1, e_drop, 5'd0, 32'h77));
      end
    end
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL drop_sat_end got=%h exp=%h", dut_v, exp_v); end
  endtask

  task automatic test_reset_mid();
    // reset while a grant is being presented and the request is still held
    req_a = 1'b1; reg_a = 5'd9; data_a = 32'h1234;
    sb.push_back(pk(1, 0, 1, 1, e_drop, 5'd9, 32'h1234));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL rstmid_grant got=%h exp=%h", dut_v, exp_v); end
    rst = 1'b1;
    e_drop = 8'd0;
    sb.push_back(pk(0, 0, 0, 0, 8'd0, 5'd0, 32'd0));
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL rstmid_grant_rst got=%h exp=%h", dut_v, exp_v); end
    rst = 1'b0; req_a = 1'b0;
    sb.push_back(pk(0, 0, 1, 0, 8'd0, 5'd0, 32'd0));
    // reset when the sweep is presenting index 10
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (dut_v !== exp_v) begin bad++; $display("FAIL rstmid_sweep k=%0d got=%h exp=%h", k, dut_v, exp_v); end
      if (k < 10) sb.push_back(pk(0, 0, 1, 0, 8'd0, 5'(k + 1), 32'd0));
      else begin
        rst = 1'b1;
        sb.push_back(pk(0, 0, 0, 0, 8'd0, 5'd0, 32'd0));
      end
    end
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (dut_v !== exp_v) begin bad++; $display("FAIL rstmid_sweep_rst got=%h exp=%h", dut_v, exp_v); end
    rst = 1'b0;
    sb.push_back(pk(0, 0, 1, 0, 8'd0, 5'd0, 32'd0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (dut_v !== exp_v) begin bad++; $display("FAIL rstmid_restart k=%0d got=%h exp=%h", k, dut_v, exp_v); end
      if (k < 2) sb.push_back(pk(0, 0, 1, 0, 8'd0, 5'(k + 1), 32'd0));
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_single_a();
    test_drop_b();
    test_back_to_back();
    test_same_reg();
    test_drop_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
